// File: rtl/dmem_responder.sv
// Byte-addressed data memory slave with a fixed request-to-response latency.
// Serves RISC-V style loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) one at a time.
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [7:0]    addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q;
    logic [7:0]    mem_q [DEPTH];

    logic          accept_s, enter_resp_s, bad_s, commit_s;
    logic          op_we_s;
    logic [2:0]    op_f3_s;
    logic [7:0]    op_addr_s;
    logic [31:0]   op_wdata_s, word_s;
    logic [AW-1:0] idx0_s, idx1_s, idx2_s, idx3_s;

    function automatic logic [AW-1:0] lane_idx(input logic [7:0] a, input logic [1:0] k);
        return AW'(({24'd0, a} + {30'd0, k}) % DEPTH);
    endfunction

    function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [7:0] a);
        logic bad_f3;
        logic misaligned;
        bad_f3     = we ? ((f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010))
                        : ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        return bad_f3 | misaligned;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b010:  r = w;
            3'b100:  r = {24'd0, w[7:0]};
            3'b101:  r = {16'd0, w[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // In IDLE the operation is the live request (needed when LATENCY=1 commits at the accept edge).
    always_comb begin
        if (state_q == IDLE) begin
            op_we_s    = req_we;
            op_f3_s    = req_func3;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
        end else begin
            op_we_s    = we_q;
            op_f3_s    = f3_q;
            op_addr_s  = addr_q;
            op_wdata_s = wdata_q;
        end
    end

    assign idx0_s   = lane_idx(op_addr_s, 2'd0);
    assign idx1_s   = lane_idx(op_addr_s, 2'd1);
    assign idx2_s   = lane_idx(op_addr_s, 2'd2);
    assign idx3_s   = lane_idx(op_addr_s, 2'd3);
    assign word_s   = {mem_q[idx3_s], mem_q[idx2_s], mem_q[idx1_s], mem_q[idx0_s]};
    assign bad_s    = access_bad(op_we_s, op_f3_s, op_addr_s);
    assign accept_s = (state_q == IDLE) && req_valid;
    assign commit_s = enter_resp_s && op_we_s && !bad_s;
    assign rdata_d  = (bad_s || op_we_s) ? 32'd0 : load_ext(op_f3_s, word_s);

    // Next-state and wait-counter logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enter_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    cnt_d        = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control state, captured request and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_s) begin
                we_q    <= req_we;
                f3_q    <= req_func3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp_s) begin
                rdata_q <= rdata_d;
                err_q   <= bad_s;
            end else if ((state_q == RESP) && rsp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    // Storage is never cleared; reset only suppresses a commit on the same edge.
    always_ff @(posedge clk) begin
        if (commit_s && !rst) begin
            case (op_f3_s)
                3'b000: mem_q[idx0_s] <= op_wdata_s[7:0];
                3'b001: begin
                    mem_q[idx0_s] <= op_wdata_s[7:0];
                    mem_q[idx1_s] <= op_wdata_s[15:8];
                end
                3'b010: begin
                    mem_q[idx0_s] <= op_wdata_s[7:0];
                    mem_q[idx1_s] <= op_wdata_s[15:8];
                    mem_q[idx2_s] <= op_wdata_s[23:16];
                    mem_q[idx3_s] <= op_wdata_s[31:24];
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table driven through a scoreboard,
// plus hand-written backpressure and reset-abort sequences.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        chk_data;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic chk,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.chk_data = chk; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " rsp_valid seen"}, {31'd0, rsp_valid}, 32'd1);
    endtask

    // Full transaction with rsp_ready=1; called and returns at a negedge.
    task automatic issue(input vec_t v, input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_func3 = v.f3;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        rsp_ready = 1'b1;
        e.chk_data = v.chk_data;
        e.rdata    = v.exp_rdata;
        e.err      = v.exp_err;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        wait_valid(name, n);
        check({name, " latency"}, n, LAT);
        e = sb_q.pop_front();
        if (e.chk_data) check({name, " rdata"}, rsp_rdata, e.rdata);
        check({name, " err"}, {31'd0, rsp_err}, {31'd0, e.err});
        @(negedge clk);
        check({name, " released"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic reset_pulse(input string name);
        rst = 1'b1;
        #1;
        check({name, " rst req_ready"}, {31'd0, req_ready}, 32'd1);
        check({name, " rst rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({name, " rst rdata"}, rsp_rdata, 32'd0);
        check({name, " rst err"}, {31'd0, rsp_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        vecs.push_back(mk(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 3'b000, 8'h13, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0));
        vecs.push_back(mk(1'b0, 3'b100, 8'h13, 32'h0, 1'b1, 32'h000000DE, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 8'h12, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0));
        vecs.push_back(mk(1'b0, 3'b101, 8'h10, 32'h0, 1'b1, 32'h0000BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 3'b000, 8'h11, 32'h00000055, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 8'h10, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 8'h12, 32'h0, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 3'b001, 8'h11, 32'h0000FFFF, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 3'b010, 8'h10, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0));
        vecs.push_back(mk(1'b1, 3'b001, 8'h12, 32'hAAAA1234, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 8'h10, 32'h0, 1'b1, 32'h123455EF, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 8'h10, 32'h0, 1'b1, 32'h000055EF, 1'b0));
        vecs.push_back(mk(1'b0, 3'b000, 8'h13, 32'h0, 1'b1, 32'h00000012, 1'b0));
        vecs.push_back(mk(1'b0, 3'b011, 8'h10, 32'h0, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 3'b110, 8'h10, 32'h0, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 3'b100, 8'h10, 32'h0, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 3'b011, 8'h10, 32'h0, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 3'b001, 8'h13, 32'h0, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 3'b010, 8'h10, 32'h0, 1'b1, 32'h123455EF, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 8'hFC, 32'h80A0B0C0, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 8'hFC, 32'h0, 1'b1, 32'h80A0B0C0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b000, 8'hFF, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 3'b101, 8'hFE, 32'h0, 1'b1, 32'h000080A0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 8'hFC, 32'h0, 1'b1, 32'hFFFFB0C0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b100, 8'hFD, 32'h0, 1'b1, 32'h000000B0, 1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 8'h20, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 8'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0));

        #2;
        reset_pulse("init");
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: response held 5 cycles while a stray store is presented.
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 8'h10; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'h00000000;
        wait_valid("hold", n);
        check("hold latency", n, LAT);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("hold%0d rdata", i), rsp_rdata, 32'h123455EF);
            check($sformatf("hold%0d err", i), {31'd0, rsp_err}, 32'd0);
            check($sformatf("hold%0d req_ready", i), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("release no accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        issue(mk(1'b0, 3'b010, 8'h10, 32'h0, 1'b1, 32'h123455EF, 1'b0), "after_hold");

        // Reset during BUSY aborts the store.
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 8'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_pulse("busy");
        issue(mk(1'b0, 3'b010, 8'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0), "after_busy_rst");

        // Reset in RESP drops a load response.
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 8'h20;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_valid("resp_ld", n);
        check("resp_ld rdata", rsp_rdata, 32'hCAFEF00D);
        reset_pulse("resp_ld");

        // Reset in RESP keeps an already committed store.
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 8'h24; req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_valid("resp_st", n);
        reset_pulse("resp_st");
        rsp_ready = 1'b1;
        issue(mk(1'b0, 3'b010, 8'h24, 32'h0, 1'b1, 32'h11223344, 1'b0), "after_resp_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving cycles from request acceptance to response valid (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH, default 256, giving byte-addressed storage size.
REQ-003 Port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1: initiator presents a request.
REQ-006 Port req_ready, output, 1: responder can accept a request.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_func3, input, 3: access size/sign, RISC-V load/store funct3 encoding.
REQ-009 Port req_addr, input, 8: byte address.
REQ-010 Port req_wdata, input, 32: store data, right-aligned.
REQ-011 Port rsp_valid, output, 1: response available.
REQ-012 Port rsp_ready, input, 1: initiator accepts response.
REQ-013 Port rsp_rdata, output, 32: load result, extended per func3.
REQ-014 Port rsp_err, output, 1: request rejected (misaligned or illegal func3).

Function
REQ-015 FSM states SHALL be IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; we, func3, addr, wdata captured into internal registers at that edge.
REQ-017 On acceptance: LATENCY=1 -> RESP directly; LATENCY>1 -> BUSY with wait counter loaded to LATENCY-1.
REQ-018 BUSY SHALL decrement the counter each cycle and move to RESP on the edge where the counter reaches 1.
REQ-019 rsp_valid SHALL rise exactly LATENCY cycles after the accepting edge and stay high, with rsp_rdata/rsp_err stable, until an edge with rsp_ready=1.
REQ-020 An edge in RESP with rsp_ready=1 SHALL return to IDLE, clear rsp_valid, and may not accept a new request on that same edge.
REQ-021 Store commit SHALL occur on the edge entering RESP; loads SHALL sample storage on that same edge.
REQ-022 Loads: 000 LB sign-extend byte; 001 LH sign-extend halfword; 010 LW word; 100 LBU zero-extend byte; 101 LHU zero-extend halfword.
REQ-023 Stores: 000 SB writes byte addr; 001 SH writes bytes addr..addr+1; 010 SW writes addr..addr+3; other bytes unchanged.
REQ-024 Byte order SHALL be little-endian: lowest address holds bits 7:0.
REQ-025 Halfword with addr[0]=1, word with addr[1:0]!=0, any load func3 of 011/110/111, or any store func3 other than 000/001/010 SHALL give rsp_err=1, rsp_rdata=0, and no storage change.
REQ-026 Successful responses SHALL drive rsp_err=0.
REQ-027 Address indexes SHALL use addr modulo DEPTH; aligned accesses never span the top boundary.
REQ-028 req_valid while not in IDLE SHALL be ignored; inputs changing after acceptance SHALL not affect the pending operation.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 Reset during BUSY SHALL abort the operation with no storage write; reset in RESP SHALL drop the response (already-committed store persists).
REQ-031 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (LATENCY=2) -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 After REQ-032: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-034 SB 0x11 data 0x00000055 then LW 0x10 -> 0xDEAD55EF.
REQ-035 LW 0x12 and SH 0x11 -> rsp_err=1, rdata 0, subsequent LW 0x10 unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, extra req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-037 SW 0x20 0x12345678, assert rst during BUSY -> outputs at reset values immediately; LW 0x20 returns prior contents.
